// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the default geometry and the bulk-clear FSM state encoding.
package reg_file_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/flop_r.sv
// Enabled D flip-flop bank with asynchronous active-high reset to zero.
// Ports: clk, rst, en (load enable), d (next value), q (stored value).
module flop_r #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rf_clear_fsm.sv
// Sequential bulk-clear engine: walks registers 1..NREG-1, one per cycle.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_clr_req    clear request, honoured only while idle
//   o_clr_busy   high in CLEAR and DONE
//   o_clr_done   one-cycle pulse in DONE
//   clr_we       zero-write strobe for the register at clr_addr
//   clr_addr     register being cleared this cycle
module rf_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr_req,
    output logic          o_clr_busy,
    output logic          o_clr_done,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = AW'(1); // register 0 is never stored
                end
            end
            CLEAR: begin
                // Exit on the last index so the counter never wraps.
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign clr_we     = (state_q == CLEAR);
    assign clr_addr   = cnt_q;
    assign o_clr_busy = (state_q == CLEAR) || (state_q == DONE);
    assign o_clr_done = (state_q == DONE);

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with pending-write
// scoreboard and sequential bulk-clear engine.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_rd_en/i_rd_addr        per-port read enable and packed addresses
//   o_rd_dat                 packed registered read data (1-cycle latency)
//   i_wr_en/addr/dat         write port, ignored while clearing
//   i_sb_set_en/addr         mark register pending (idle only)
//   o_sb_busy                scoreboard, bit n = register n pending
//   i_clr_req                bulk-clear request
//   o_clr_busy/o_clr_done    clear engine status
//   i_debug_addr             debug read address
//   o_debug_data             registered debug read data, never bypassed
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned AW     = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD-1:0]      i_rd_en,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_dat,
    input  logic                i_wr_en,
    input  logic [AW-1:0]       i_wr_addr,
    input  logic [XLEN-1:0]     i_wr_dat,
    input  logic                i_sb_set_en,
    input  logic [AW-1:0]       i_sb_set_addr,
    output logic [NREG-1:0]     o_sb_busy,
    input  logic                i_clr_req,
    output logic                o_clr_busy,
    output logic                o_clr_done,
    input  logic [AW-1:0]       i_debug_addr,
    output logic [XLEN-1:0]     o_debug_data
);

    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            idle;
    logic            user_we;
    logic            wr_we;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_dat;
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rd_next [NRD];
    logic [AW-1:0]   rd_addr [NRD];
    logic [NREG-1:0] busy_q, busy_d;

    rf_clear_fsm #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (i_clr_req),
        .o_clr_busy (o_clr_busy),
        .o_clr_done (o_clr_done),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr)
    );

    // The engine owns the write port whenever it is not idle.
    assign idle    = ~o_clr_busy;
    assign user_we = idle && i_wr_en && (i_wr_addr != '0);
    assign wr_we   = user_we || clr_we;
    assign wr_addr = clr_we ? clr_addr : i_wr_addr;
    assign wr_dat  = clr_we ? '0 : i_wr_dat;

    assign regs[0] = '0;

    for (genvar n = 1; n < NREG; n++) begin : g_reg
        flop_r #(
            .W (XLEN)
        ) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (wr_we && (wr_addr == AW'(n))),
            .d   (wr_dat),
            .q   (regs[n])
        );
    end

    // Read mux; with bypass a same-cycle write (including a clear zero) wins.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_addr[k] = i_rd_addr[k*AW +: AW];
            rd_next[k] = regs[rd_addr[k]];
            if ((BYPASS != 0) && wr_we && (wr_addr == rd_addr[k])) begin
                rd_next[k] = wr_dat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_dat <= '0;
        end else begin
            for (int k = 0; k < NRD; k++) begin
                if (i_rd_en[k]) begin
                    o_rd_dat[k*XLEN +: XLEN] <= rd_next[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_debug_data <= '0;
        end else begin
            o_debug_data <= regs[i_debug_addr];
        end
    end

    // Set is applied after clear so a new producer supersedes the old one.
    always_comb begin
        busy_d = busy_q;
        if (wr_we) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (idle && i_sb_set_en) begin
            busy_d[i_sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_sb_busy = busy_q;

endmodule
